// File: rtl/fg_zone_detector.sv
// Counts foreground (non-background) pixels in four side-by-side zones per frame and reports per-zone hits.
// Optional FG_ZONE_DEBOUNCE_EN: a zone only reports a hit when it was hit in two consecutive frames.
module fg_zone_detector #(
  parameter logic [9:0]  ZONE_Y0 = 10'd0,
  parameter logic [9:0]  ZONE_H  = 10'd120,
  parameter logic [14:0] HIT_TH  = 15'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        bg_pixel,
  output logic [3:0]  hit,
  output logic        hit_valid,
  output logic [14:0] zone_cnt_max
);

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, REPORT} state_t;

  state_t      state, state_next;
  logic        frame_start, frame_end, in_band;
  logic [3:0]  zone_hit;
  logic [14:0] cnt [4];
  logic [3:0]  raw, raw_next;
  logic [14:0] max_next, max_01, max_23;
  logic [10:0] y_lo, y_hi;

  assign frame_start = DE && (x_pixel == 10'd0)   && (y_pixel == 10'd0);
  assign frame_end   = DE && (x_pixel == 10'd639) && (y_pixel == 10'd479);

  // Band bounds are widened to 11 bits so ZONE_Y0 + ZONE_H cannot overflow.
  assign y_lo    = {1'b0, ZONE_Y0};
  assign y_hi    = y_lo + {1'b0, ZONE_H};
  assign in_band = ({1'b0, y_pixel} >= y_lo) && ({1'b0, y_pixel} < y_hi);

  always_comb begin
    zone_hit = 4'b0000;
    if (DE && !bg_pixel && in_band) begin
      if (x_pixel < 10'd160)      zone_hit[0] = 1'b1;
      else if (x_pixel < 10'd320) zone_hit[1] = 1'b1;
      else if (x_pixel < 10'd480) zone_hit[2] = 1'b1;
      else if (x_pixel < 10'd640) zone_hit[3] = 1'b1;
    end
  end

  // A frame-start pixel restarts the counts and is itself counted; counts saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) cnt[k] <= 15'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (frame_start)
          cnt[k] <= {14'd0, zone_hit[k]};
        else if (state == IDLE)
          cnt[k] <= 15'd0;
        else if (zone_hit[k] && (cnt[k] != 15'h7FFF))
          cnt[k] <= cnt[k] + 15'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = ACCUM;
      ACCUM:   if (frame_end)   state_next = EVAL;
      EVAL:    state_next = REPORT;
      REPORT:  state_next = ACCUM;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) raw_next[k] = (cnt[k] >= HIT_TH);
    max_01   = (cnt[0] >= cnt[1]) ? cnt[0] : cnt[1];
    max_23   = (cnt[2] >= cnt[3]) ? cnt[2] : cnt[3];
    max_next = (max_01 >= max_23) ? max_01 : max_23;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw          <= 4'b0000;
      zone_cnt_max <= 15'd0;
    end else if (state == EVAL) begin
      raw          <= raw_next;
      zone_cnt_max <= max_next;
    end
  end

  assign hit_valid = (state == REPORT);

`ifdef FG_ZONE_DEBOUNCE_EN
  logic [3:0] prev_raw;
  logic [3:0] hit_q;

  // The new hit is formed as EVAL closes so it is already stable during the REPORT pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_raw <= 4'b0000;
      hit_q    <= 4'b0000;
    end else begin
      if (state == EVAL)   hit_q    <= raw_next & prev_raw;
      if (state == REPORT) prev_raw <= raw;
    end
  end

  assign hit = hit_q;
`else
  assign hit = raw;
`endif

endmodule

// File: tb/tb_fg_zone_detector.sv
// Scoreboard bench for fg_zone_detector: reduced zone band so complete frames stay short.
// Expected reports are queued at each frame end and checked by an independent monitor.
module tb_fg_zone_detector;

  localparam logic [9:0]  TB_Y0 = 10'd2;
  localparam logic [9:0]  TB_H  = 10'd8;
  localparam logic [14:0] TB_TH = 15'd300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        de = 1'b0;
  logic [9:0]  x_pixel = 10'd0;
  logic [9:0]  y_pixel = 10'd0;
  logic        bg_pixel = 1'b1;
  logic [3:0]  hit;
  logic        hit_valid;
  logic [14:0] zone_cnt_max;

  int cycle = 0;
  int n_compared = 0;
  int n_mismatched = 0;
  logic [3:0] prev_raw_model = 4'b0000;

  typedef struct {
    logic [3:0]  hit;
    logic [14:0] max;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  fg_zone_detector #(.ZONE_Y0(TB_Y0), .ZONE_H(TB_H), .HIT_TH(TB_TH)) dut (
    .clk(clk), .reset(reset), .DE(de), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .bg_pixel(bg_pixel), .hit(hit), .hit_valid(hit_valid), .zone_cnt_max(zone_cnt_max)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic apply_stimulus(input logic de_i, input int x, input int y, input logic bg);
    de       = de_i;
    x_pixel  = 10'(x);
    y_pixel  = 10'(y);
    bg_pixel = bg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 0, 0, 1'b1);
  endtask

  task automatic fg_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) apply_stimulus(1'b1, x, y, 1'b0);
  endtask

  task automatic fg_repeat(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, x, y, 1'b0);
  endtask

  task automatic frame_begin();
    apply_stimulus(1'b1, 0, 0, 1'b0);
  endtask

  task automatic frame_end_silent();
    apply_stimulus(1'b1, 639, 479, 1'b0);
  endtask

  // The report pulse must appear two cycles after the frame-end pixel cycle.
  task automatic frame_end_report(input logic [3:0] raw, input logic [14:0] mx);
    exp_t e;
    frame_end_silent();
`ifdef FG_ZONE_DEBOUNCE_EN
    e.hit = raw & prev_raw_model;
`else
    e.hit = raw;
`endif
    e.max = mx;
    e.cyc = cycle + 1;
    prev_raw_model = raw;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && hit_valid) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_report: hit=%b max=%0d at cycle %0d, required no report", hit, zone_cnt_max, cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("report_hit", 32'(hit), 32'(e.hit));
        check_output("report_max", 32'(zone_cnt_max), 32'(e.max));
        check_output("report_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hit", 32'(hit), 32'd0);
    check_output("reset_hit_valid", 32'(hit_valid), 32'd0);
    check_output("reset_max", 32'(zone_cnt_max), 32'd0);
    reset = 1'b0;
    idle(3);

    // Every zone pixel foreground.
    frame_begin();
    fg_rect(0, 639, 2, 9);
    frame_end_report(4'b1111, 15'd1280);
    idle(4);

    // Zone 1 only; DE=0 and background pixels elsewhere must not count.
    frame_begin();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 10, 5, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 330, 5, 1'b1);
    fg_rect(160, 319, 2, 9);
    frame_end_report(4'b0010, 15'd1280);
    idle(4);

    // Threshold is inclusive: 299 in zone 2, 300 in zone 3.
    frame_begin();
    fg_rect(320, 479, 2, 2);
    fg_rect(320, 458, 3, 3);
    fg_rect(480, 639, 2, 2);
    fg_rect(480, 619, 3, 3);
    frame_end_report(4'b1000, 15'd300);
    idle(4);

    // Saturation of a single zone counter.
    frame_begin();
    fg_repeat(0, 2, 32800);
    frame_end_report(4'b0001, 15'd32767);
    idle(4);

    // Band and zone edges.
    frame_begin();
    apply_stimulus(1'b1, 159, 9, 1'b0);
    apply_stimulus(1'b1, 160, 9, 1'b0);
    apply_stimulus(1'b1, 159, 10, 1'b0);
    apply_stimulus(1'b1, 160, 10, 1'b0);
    apply_stimulus(1'b1, 159, 2, 1'b0);
    apply_stimulus(1'b1, 0, 1, 1'b0);
    apply_stimulus(1'b1, 639, 10, 1'b0);
    frame_end_report(4'b0000, 15'd2);
    idle(4);

    // Next frame starts during EVAL; both reports must still be correct.
    frame_begin();
    fg_repeat(200, 5, 300);
    frame_end_report(4'b0010, 15'd300);
    frame_begin();
    fg_repeat(10, 9, 300);
    frame_end_report(4'b0001, 15'd300);
    idle(4);

    // Reset mid-frame, then the remainder of that frame must not report.
    frame_begin();
    fg_repeat(0, 5, 200);
    apply_stimulus(1'b1, 0, 200, 1'b0);
    reset = 1'b1;
    prev_raw_model = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("midreset_hit", 32'(hit), 32'd0);
    check_output("midreset_hit_valid", 32'(hit_valid), 32'd0);
    check_output("midreset_max", 32'(zone_cnt_max), 32'd0);
    reset = 1'b0;
    fg_repeat(0, 5, 200);
    frame_end_silent();
    idle(6);

    // Hit pattern for zone 0 across four frames: hit, miss, hit, hit.
    frame_begin();
    fg_repeat(0, 5, 300);
    frame_end_report(4'b0001, 15'd300);
    idle(3);
    frame_begin();
    fg_repeat(0, 5, 299);
    frame_end_report(4'b0000, 15'd299);
    idle(3);
    frame_begin();
    fg_repeat(0, 5, 300);
    frame_end_report(4'b0001, 15'd300);
    idle(3);
    frame_begin();
    fg_repeat(0, 5, 310);
    frame_end_report(4'b0001, 15'd310);
    idle(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL missing_report: %0d reports outstanding, required 0", exp_q.size());
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
